// File: rtl/operand_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// operand_fetch_stage_pkg
// Shared constants for the operand fetch stage and its scoreboard.
//   REG_IDX_W    : width of an architectural register index
//   NUM_REGS     : number of architectural registers
//   XLEN_DEFAULT : default data / PC width
//   ZERO_REG     : hard-wired zero register index
// Helper function idx_hit: qualified index equality used by forwarding and
// scoreboard update logic.
// -----------------------------------------------------------------------------
package operand_fetch_stage_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int NUM_REGS     = 32;
  localparam int XLEN_DEFAULT = 32;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

  // True when the qualifier is set and both indices name the same register.
  function automatic logic idx_hit(
    input logic                 en,
    input logic [REG_IDX_W-1:0] idx_a,
    input logic [REG_IDX_W-1:0] idx_b
  );
    return en && (idx_a == idx_b);
  endfunction

endpackage

// File: rtl/operand_fetch_stage_scoreboard.sv
// -----------------------------------------------------------------------------
// op_scoreboard
// Per-register count of in-flight writes. Entry 0 (x0) is never tracked.
// Ports:
//   clock, reset_n      : rising-edge clock, asynchronous active-low reset
//   inc_en, inc_idx     : a writer of inc_idx was issued this cycle
//   dec_en, dec_idx     : a writeback to dec_idx happens this cycle
//   rs1_idx, rs1_cnt    : count lookup for source 1
//   rs2_idx, rs2_cnt    : count lookup for source 2
//   sat_flags           : one bit per register, set when its count is at max
// -----------------------------------------------------------------------------
module op_scoreboard
  import operand_fetch_stage_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 inc_en,
  input  logic [REG_IDX_W-1:0] inc_idx,
  input  logic                 dec_en,
  input  logic [REG_IDX_W-1:0] dec_idx,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  output logic [CNT_W-1:0]     rs1_cnt,
  output logic [CNT_W-1:0]     rs2_cnt,
  output logic [NUM_REGS-1:0]  sat_flags
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0]    cnt_r [NUM_REGS];
  logic [NUM_REGS-1:0] inc_hit_s;
  logic [NUM_REGS-1:0] dec_hit_s;

  // Decode the inc/dec requests into per-register strobes and saturation flags.
  always_comb begin
    inc_hit_s = {NUM_REGS{1'b0}};
    dec_hit_s = {NUM_REGS{1'b0}};
    sat_flags = {NUM_REGS{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      inc_hit_s[i] = idx_hit(inc_en, inc_idx, REG_IDX_W'(i));
      dec_hit_s[i] = idx_hit(dec_en, dec_idx, REG_IDX_W'(i));
      sat_flags[i] = (cnt_r[i] == CNT_MAX);
    end
  end

  // Counter update: simultaneous inc and dec cancel, dec at zero is dropped,
  // inc at max is held (issue logic already blocks that case).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      cnt_r[0] <= CNT_ZERO;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (inc_hit_s[i] && !dec_hit_s[i] && !sat_flags[i]) begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end else if (dec_hit_s[i] && !inc_hit_s[i] && (cnt_r[i] != CNT_ZERO)) begin
          cnt_r[i] <= cnt_r[i] - CNT_ONE;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  assign rs1_cnt = cnt_r[rs1_idx];
  assign rs2_cnt = cnt_r[rs2_idx];

endmodule

// File: rtl/operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// operand_fetch_stage
// Reads the register file for a decoded instruction, forwards a same-cycle
// writeback, blocks issue on outstanding writes to a source (or on a full
// destination counter) and registers the result into the ID/EX boundary.
// Ports:
//   clock, reset_n              : rising-edge clock, async active-low reset
//   in_valid/in_ready           : decode-side handshake
//   in_pc, in_rs1, in_rs2       : instruction PC and source indices
//   in_use_rs1, in_use_rs2      : source read qualifiers
//   in_rd, in_rd_we             : destination index and write enable
//   rf_addr_rs1/2, rf_data_rs1/2: register file read port
//   wb_valid, wb_rd, wb_data    : writeback bus (same as RF write port)
//   out_valid/out_ready         : execute-side handshake
//   out_pc, out_rs1_data, out_rs2_data, out_rd, out_rd_we : registered payload
//   stall_cycles                : only with OPFETCH_PERF_EN, saturating count of
//                                 cycles with in_valid high and in_ready low
// Configuration macro: OPFETCH_PERF_EN
// -----------------------------------------------------------------------------
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int CNT_W = 2,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [REG_IDX_W-1:0] in_rs1,
  input  logic [REG_IDX_W-1:0] in_rs2,
  input  logic                 in_use_rs1,
  input  logic                 in_use_rs2,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_rd_we,
  output logic [REG_IDX_W-1:0] rf_addr_rs1,
  output logic [REG_IDX_W-1:0] rf_addr_rs2,
  input  logic [XLEN-1:0]      rf_data_rs1,
  input  logic [XLEN-1:0]      rf_data_rs2,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_rs1_data,
  output logic [XLEN-1:0]      out_rs2_data,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_rd_we
`ifdef OPFETCH_PERF_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]    rs1_cnt_s;
  logic [CNT_W-1:0]    rs2_cnt_s;
  logic [NUM_REGS-1:0] sat_flags_s;
  logic [XLEN-1:0]     rs1_sel_s;
  logic [XLEN-1:0]     rs2_sel_s;
  logic                hazard_rs1_s;
  logic                hazard_rs2_s;
  logic                full_rd_s;
  logic                accept_s;
  logic                sb_inc_s;
  logic                sb_dec_s;

  logic                out_valid_r;
  logic [XLEN-1:0]     out_pc_r;
  logic [XLEN-1:0]     out_rs1_data_r;
  logic [XLEN-1:0]     out_rs2_data_r;
  logic [REG_IDX_W-1:0] out_rd_r;
  logic                out_rd_we_r;

  assign rf_addr_rs1 = in_rs1;
  assign rf_addr_rs2 = in_rs2;

  assign sb_inc_s = accept_s && in_rd_we && (in_rd != ZERO_REG);
  assign sb_dec_s = wb_valid && (wb_rd != ZERO_REG);

  op_scoreboard #(
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clock     (clock),
    .reset_n   (reset_n),
    .inc_en    (sb_inc_s),
    .inc_idx   (in_rd),
    .dec_en    (sb_dec_s),
    .dec_idx   (wb_rd),
    .rs1_idx   (in_rs1),
    .rs2_idx   (in_rs2),
    .rs1_cnt   (rs1_cnt_s),
    .rs2_cnt   (rs2_cnt_s),
    .sat_flags (sat_flags_s)
  );

  // Operand select: x0 reads zero, a same-cycle writeback wins over RF data.
  always_comb begin
    rs1_sel_s = rf_data_rs1;
    rs2_sel_s = rf_data_rs2;
    if (in_rs1 == ZERO_REG) begin
      rs1_sel_s = {XLEN{1'b0}};
    end else if (idx_hit(wb_valid, wb_rd, in_rs1)) begin
      rs1_sel_s = wb_data;
    end else begin
      rs1_sel_s = rf_data_rs1;
    end
    if (in_rs2 == ZERO_REG) begin
      rs2_sel_s = {XLEN{1'b0}};
    end else if (idx_hit(wb_valid, wb_rd, in_rs2)) begin
      rs2_sel_s = wb_data;
    end else begin
      rs2_sel_s = rf_data_rs2;
    end
  end

  // Issue checks: a source is clear when its last outstanding write lands now;
  // a full destination counter frees up if one of its writes lands now.
  always_comb begin
    hazard_rs1_s = in_use_rs1 && (in_rs1 != ZERO_REG) && (rs1_cnt_s != CNT_ZERO) &&
                   !(idx_hit(wb_valid, wb_rd, in_rs1) && (rs1_cnt_s == CNT_ONE));
    hazard_rs2_s = in_use_rs2 && (in_rs2 != ZERO_REG) && (rs2_cnt_s != CNT_ZERO) &&
                   !(idx_hit(wb_valid, wb_rd, in_rs2) && (rs2_cnt_s == CNT_ONE));
    full_rd_s    = in_rd_we && (in_rd != ZERO_REG) && sat_flags_s[in_rd] &&
                   !idx_hit(wb_valid, wb_rd, in_rd);
  end

  // in_ready intentionally excludes in_valid to avoid a valid->ready loop.
  assign in_ready = !hazard_rs1_s && !hazard_rs2_s && !full_rd_s &&
                    (!out_valid_r || out_ready);
  assign accept_s = in_valid && in_ready;

  // ID/EX boundary register: load on accept, drop valid when consumed, else hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r    <= 1'b0;
      out_pc_r       <= {XLEN{1'b0}};
      out_rs1_data_r <= {XLEN{1'b0}};
      out_rs2_data_r <= {XLEN{1'b0}};
      out_rd_r       <= ZERO_REG;
      out_rd_we_r    <= 1'b0;
    end else if (accept_s) begin
      out_valid_r    <= 1'b1;
      out_pc_r       <= in_pc;
      out_rs1_data_r <= rs1_sel_s;
      out_rs2_data_r <= rs2_sel_s;
      out_rd_r       <= in_rd;
      out_rd_we_r    <= in_rd_we;
    end else if (out_ready) begin
      out_valid_r    <= 1'b0;
    end else begin
      out_valid_r    <= out_valid_r;
    end
  end

  assign out_valid    = out_valid_r;
  assign out_pc       = out_pc_r;
  assign out_rs1_data = out_rs1_data_r;
  assign out_rs2_data = out_rs2_data_r;
  assign out_rd       = out_rd_r;
  assign out_rd_we    = out_rd_we_r;

`ifdef OPFETCH_PERF_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles where decode offers an instruction we refuse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_r <= 32'd0;
    end else if (in_valid && !in_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic        in_use_rs1;
  logic        in_use_rs2;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic [4:0]  rf_addr_rs1;
  logic [4:0]  rf_addr_rs2;
  logic [31:0] rf_data_rs1;
  logic [31:0] rf_data_rs2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_data;
  logic [31:0] out_rs2_data;
  logic [4:0]  out_rd;
  logic        out_rd_we;
`ifdef OPFETCH_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_tests;
  int n_fail;

  operand_fetch_stage dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_use_rs1   (in_use_rs1),
    .in_use_rs2   (in_use_rs2),
    .in_rd        (in_rd),
    .in_rd_we     (in_rd_we),
    .rf_addr_rs1  (rf_addr_rs1),
    .rf_addr_rs2  (rf_addr_rs2),
    .rf_data_rs1  (rf_data_rs1),
    .rf_data_rs2  (rf_data_rs2),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_rd       (out_rd),
    .out_rd_we    (out_rd_we)
`ifdef OPFETCH_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    in_valid = 1'b0; in_pc = 32'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_rd = 5'd0; in_rd_we = 1'b0;
    rf_data_rs1 = 32'd0; rf_data_rs2 = 32'd0;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    reset_n = 1'b0;
    #3;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_tests++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
    n_tests++; if ({out_rs1_data, out_rs2_data} !== 64'd0) begin n_fail++; $display("FAIL reset_out_data got %h/%h exp 0", out_rs1_data, out_rs2_data); end
    n_tests++; if ({out_rd, out_rd_we} !== 6'd0) begin n_fail++; $display("FAIL reset_out_rd got %h/%b exp 0", out_rd, out_rd_we); end
    #4;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic_issue();
    in_valid = 1'b1; in_pc = 32'h100; in_rs1 = 5'd3; in_rs2 = 5'd4;
    in_use_rs1 = 1'b1; in_use_rs2 = 1'b1; rf_data_rs1 = 32'h11; rf_data_rs2 = 32'h22;
    in_rd = 5'd5; in_rd_we = 1'b1;
    #1;
    n_tests++; if (rf_addr_rs1 !== 5'd3 || rf_addr_rs2 !== 5'd4) begin n_fail++; $display("FAIL rf_addr got %0d/%0d exp 3/4", rf_addr_rs1, rf_addr_rs2); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %b exp 1", in_ready); end
    step();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    n_tests++; if (out_rs1_data !== 32'h11 || out_rs2_data !== 32'h22) begin n_fail++; $display("FAIL basic_data got %h/%h exp 11/22", out_rs1_data, out_rs2_data); end
    n_tests++; if (out_pc !== 32'h100 || out_rd !== 5'd5 || out_rd_we !== 1'b1) begin n_fail++; $display("FAIL basic_meta got %h/%0d/%b exp 100/5/1", out_pc, out_rd, out_rd_we); end
    set_idle();
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_hazard_forward();
    // x5 has one write in flight from test_basic_issue.
    in_valid = 1'b1; in_pc = 32'h104; in_rs1 = 5'd5; in_use_rs1 = 1'b1; rf_data_rs1 = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_%0d got %b exp 0", i, in_ready); end
      step();
    end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_no_issue got %b exp 0", out_valid); end
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hABCD;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_wb_ready got %b exp 1", in_ready); end
    step();
    n_tests++; if (out_valid !== 1'b1 || out_rs1_data !== 32'hABCD || out_pc !== 32'h104) begin n_fail++; $display("FAIL raw_fwd got %b/%h/%h exp 1/abcd/104", out_valid, out_rs1_data, out_pc); end
    wb_valid = 1'b0; in_pc = 32'h108;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_cleared got %b exp 1", in_ready); end
    set_idle();
    step();
  endtask

  task automatic test_x0();
    in_valid = 1'b1; in_pc = 32'h120; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_use_rs1 = 1'b1; in_use_rs2 = 1'b1; rf_data_rs1 = 32'h5555; rf_data_rs2 = 32'hFFFF;
    in_rd = 5'd0; in_rd_we = 1'b1; wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got %b exp 1", in_ready); end
    step();
    n_tests++; if (out_rs1_data !== 32'd0 || out_rs2_data !== 32'd0) begin n_fail++; $display("FAIL x0_data got %h/%h exp 0/0", out_rs1_data, out_rs2_data); end
    wb_valid = 1'b0; in_pc = 32'h124;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL x0_untracked got %b exp 1", in_ready); end
    set_idle();
    step();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_pc = 32'h200; in_rs1 = 5'd1; in_use_rs1 = 1'b1; rf_data_rs1 = 32'h55;
    step();
    out_ready = 1'b0; in_pc = 32'h300; rf_data_rs1 = 32'h66;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_%0d got %b exp 0", i, in_ready); end
      step();
      n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_rs1_data !== 32'h55) begin n_fail++; $display("FAIL bp_hold_%0d got %b/%h/%h exp 1/200/55", i, out_valid, out_pc, out_rs1_data); end
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b exp 1", in_ready); end
    step();
    n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_rs1_data !== 32'h66) begin n_fail++; $display("FAIL bp_reload got %b/%h/%h exp 1/300/66", out_valid, out_pc, out_rs1_data); end
    set_idle();
    step();
  endtask

  task automatic test_saturation();
    in_valid = 1'b1; in_rd = 5'd7; in_rd_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h700 + 32'(4 * i);
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sat_fill_%0d got %b exp 1", i, in_ready); end
      step();
    end
    in_pc = 32'h70C;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL sat_full got %b exp 0", in_ready); end
    step();
    n_tests++; if (out_valid !== 1'b0 || out_pc !== 32'h708) begin n_fail++; $display("FAIL sat_no_issue got %b/%h exp 0/708", out_valid, out_pc); end
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sat_wb_ready got %b exp 1", in_ready); end
    step();
    n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h70C) begin n_fail++; $display("FAIL sat_wb_issue got %b/%h exp 1/70c", out_valid, out_pc); end
    // Counter must still be saturated (inc and dec cancelled).
    wb_valid = 1'b0; in_pc = 32'h710;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL sat_still_full got %b exp 0", in_ready); end
    // A reader with a wb to x7 stays blocked since more than one write is pending.
    in_rd_we = 1'b0; in_rd = 5'd0; in_rs1 = 5'd7; in_use_rs1 = 1'b1; wb_valid = 1'b1; wb_rd = 5'd7;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL sat_multi_pending got %b exp 0", in_ready); end
    set_idle();
    // Writeback to idle x8 must not wrap its counter.
    wb_valid = 1'b1; wb_rd = 5'd8;
    step();
    wb_valid = 1'b0; in_valid = 1'b1; in_pc = 32'h800; in_rd = 5'd8; in_rd_we = 1'b1;
    step();
    in_rd_we = 1'b0; in_rd = 5'd0; in_rs2 = 5'd8; in_use_rs2 = 1'b1; in_pc = 32'h804;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL dec_zero_nowrap got %b exp 0", in_ready); end
    set_idle();
    step();
  endtask

  task automatic test_reset_midflight();
    in_valid = 1'b1; in_rd = 5'd9; in_rd_we = 1'b1; in_pc = 32'h900;
    step();
    in_pc = 32'h904;
    step();
    set_idle();
    out_ready = 1'b0;
    #2;
    n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h904) begin n_fail++; $display("FAIL mid_pre got %b/%h exp 1/904", out_valid, out_pc); end
    reset_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_rd !== 5'd0) begin n_fail++; $display("FAIL mid_reset got %b/%h/%0d exp 0/0/0", out_valid, out_pc, out_rd); end
`ifdef OPFETCH_PERF_EN
    n_tests++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL mid_stall_cnt got %0d exp 0", stall_cycles); end
`endif
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'hA00;
    in_rs1 = 5'd9; in_use_rs1 = 1'b1; in_rs2 = 5'd7; in_use_rs2 = 1'b1; in_rd = 5'd7; in_rd_we = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_sb_cleared got %b exp 1", in_ready); end
    step();
    n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'hA00) begin n_fail++; $display("FAIL mid_after got %b/%h exp 1/a00", out_valid, out_pc); end
    set_idle();
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic_issue();
    test_hazard_forward();
    test_x0();
    test_back_to_back();
    test_saturation();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
